// File: rtl/fetch_queue.sv
// fetch_queue: RV32 fetch stage. Owns the PC, issues credit-limited imem requests, and buffers {instr, pc} in order.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response to decode combinationally when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          started_q;

    logic          req_fire, rsp_keep, push, pop, q_valid, bypass_take;
    logic [CW:0]   inflight;
    logic [31:0]   rsp_pc;

    // started_q holds requests off until the first edge after reset release.
    assign inflight       = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = started_q && (inflight < (CW+1)'(DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Kept requests are consecutive words ending at fetch_pc, so the oldest one's PC is recoverable.
    assign rsp_pc   = fetch_pc_q - (32'(outstanding_q) << 2);
    assign rsp_keep = imem_rsp_valid && (discard_q == '0) && !redirect;
    assign q_valid  = (count_q != '0);
    assign pop      = q_valid && instr_ready;
    assign push     = rsp_keep && !bypass_take;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass      = !q_valid && rsp_keep;
    assign bypass_take = bypass && instr_ready;
`else
    assign bypass_take = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        instr_valid = q_valid;
        instr       = q_valid ? mem_q[rd_ptr_q].instr : '0;
        instr_pc    = q_valid ? mem_q[rd_ptr_q].pc : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            instr_valid = 1'b1;
            instr       = imem_rsp_data;
            instr_pc    = rsp_pc;
        end
`endif
    end

    always_comb begin
        fetch_pc_d    = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        discard_d     = discard_q - CW'(imem_rsp_valid && (discard_q != '0));
        // A redirect lets this cycle's pop finish, then flushes; everything still in flight goes stale.
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            started_q     <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // NOTE: queue storage has no reset; it is read only under count_q and the outputs are gated when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{instr: imem_rsp_data, pc: rsp_pc};
        end
    end

    // The credit rule guarantees a kept response always finds a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> (count_q < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table with a direct-driven memory port,
// then hand sequences against a fixed-latency memory model (stream, stall, redirect, reset, wrap).
module tb_fetch_queue;
    localparam logic [31:0] MAGIC = 32'h5A5A_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int          FIRST_K   = 2;
    localparam int          REDIR_K   = 7;
    localparam logic [31:0] ADDR_LEAD = 32'd4;
`else
    localparam int          FIRST_K   = 3;
    localparam int          REDIR_K   = 8;
    localparam logic [31:0] ADDR_LEAD = 32'd8;
`endif

    logic        clk, rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: accepts whenever mem_ready, returns addr ^ MAGIC mem_lat cycles later, in order.
    logic        mem_en, mem_ready;
    int          mem_lat;
    logic        vec_req_ready, vec_rsp_valid;
    logic [31:0] vec_rsp_data;
    logic        pipe_v [8];
    logic [31:0] pipe_a [8];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
            end
        end else begin
            pipe_v[0] <= imem_req_valid && imem_req_ready;
            pipe_a[0] <= imem_addr;
            for (int i = 1; i < 8; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign imem_req_ready = mem_en ? mem_ready : vec_req_ready;
    assign imem_rsp_valid = mem_en ? pipe_v[mem_lat-1] : vec_rsp_valid;
    assign imem_rsp_data  = mem_en ? (pipe_a[mem_lat-1] ^ MAGIC) : vec_rsp_data;

    typedef struct {
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        ir;
        logic        e_req_valid;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rdy, input logic rv,
                                input logic [31:0] rdata, input logic ir, input logic erv,
                                input logic [31:0] eaddr, input logic eiv, input logic [31:0] ein,
                                input logic [31:0] epc);
        vec_t v;
        v.redirect    = rd;
        v.redirect_pc = rpc;
        v.req_ready   = rdy;
        v.rsp_valid   = rv;
        v.rsp_data    = rdata;
        v.ir          = ir;
        v.e_req_valid = erv;
        v.e_addr      = eaddr;
        v.e_valid     = eiv;
        v.e_instr     = ein;
        v.e_pc        = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_ready   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] exp_pc;

    // Checks the head against the expected in-order PC, then drives instr_ready for the coming edge.
    task automatic stream_step(input logic ir);
        if (instr_valid) begin
            check("stream_pc", instr_pc, exp_pc);
            check("stream_instr", instr, exp_pc ^ MAGIC);
            if (ir) exp_pc = exp_pc + 32'd4;
        end
        instr_ready = ir;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rel_pc;
        logic        found;

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        mem_en = 1'b0; mem_lat = 1; mem_ready = 1'b1;
        vec_req_ready = 1'b0; vec_rsp_valid = 1'b0; vec_rsp_data = '0;
        exp_pc = '0;

        //            rd  rpc            rdy rv  data           ir  erv addr           iv  instr          pc
        vecs[0]  = mk(0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0);
        vecs[1]  = mk(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0,         32'h0);
        vecs[2]  = mk(0, 32'h0,         1, 1, 32'h1111_0000, 0, 1, 32'h4,         0, 32'h0,         32'h0);
        vecs[3]  = mk(0, 32'h0,         0, 1, 32'h2222_0004, 0, 1, 32'h8,         1, 32'h1111_0000, 32'h0);
        vecs[4]  = mk(0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h8,         1, 32'h1111_0000, 32'h0);
        vecs[5]  = mk(1, 32'h0000_0103, 1, 1, 32'hBAD0_0008, 1, 1, 32'hC,         1, 32'h2222_0004, 32'h4);
        vecs[6]  = mk(0, 32'h0,         1, 1, 32'hBAD0_000C, 1, 1, 32'h100,       0, 32'h0,         32'h0);
        vecs[7]  = mk(0, 32'h0,         0, 1, 32'h3333_0100, 0, 1, 32'h104,       0, 32'h0,         32'h0);
        vecs[8]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h104,       1, 32'h3333_0100, 32'h100);
        vecs[9]  = mk(1, 32'h0000_0200, 1, 0, 32'h0,         0, 1, 32'h104,       0, 32'h0,         32'h0);
        vecs[10] = mk(1, 32'h0000_0300, 1, 0, 32'h0,         0, 1, 32'h200,       0, 32'h0,         32'h0);
        vecs[11] = mk(0, 32'h0,         1, 1, 32'hBAD0_0104, 0, 1, 32'h300,       0, 32'h0,         32'h0);
        vecs[12] = mk(0, 32'h0,         0, 1, 32'hBAD0_0200, 0, 1, 32'h304,       0, 32'h0,         32'h0);
        vecs[13] = mk(0, 32'h0,         0, 1, 32'h4444_0300, 0, 1, 32'h304,       0, 32'h0,         32'h0);
        vecs[14] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h304,       1, 32'h4444_0300, 32'h300);
        vecs[15] = mk(0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h304,       1, 32'h4444_0300, 32'h300);
        vecs[16] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h304,       0, 32'h0,         32'h0);

        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

`ifndef FETCH_QUEUE_BYPASS_EN
        for (int i = 0; i < NVEC; i++) begin
            redirect      = vecs[i].redirect;
            redirect_pc   = vecs[i].redirect_pc;
            vec_req_ready = vecs[i].req_ready;
            vec_rsp_valid = vecs[i].rsp_valid;
            vec_rsp_data  = vecs[i].rsp_data;
            instr_ready   = vecs[i].ir;
            #1;
            check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req_valid));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
            check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].e_pc);
            @(negedge clk);
        end
        redirect = 1'b0; vec_req_ready = 1'b0; vec_rsp_valid = 1'b0; instr_ready = 1'b0;
`endif

        // Streaming at one per cycle, then a 10-cycle decode stall and release.
        mem_en = 1'b1; mem_lat = 1;
        do_reset();
        exp_pc = 32'h0;
        rel_pc = 32'h0;
        for (int k = 0; k < 40; k++) begin
            if (k == FIRST_K - 1) check("a_not_early", 32'(instr_valid), 32'd0);
            if (k >= FIRST_K && k < 10) check("a_steady_valid", 32'(instr_valid), 32'd1);
            if (k == FIRST_K) check("a_addr_lead", imem_addr, instr_pc + ADDR_LEAD);
            if (k == 19) begin
                check("a_saturated_req_valid", 32'(imem_req_valid), 32'd0);
                check("a_stalled_instr_valid", 32'(instr_valid), 32'd1);
            end
            if (k == 20) rel_pc = exp_pc;
            stream_step(!(k >= 10 && k < 20));
        end
        check("a_drain_progress", 32'((exp_pc - rel_pc) >= 32'd16), 32'd1);

        // 3-cycle memory, two requests in flight, redirect to an unaligned target.
        mem_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("c_two_in_flight_addr", imem_addr, 32'h8);
        redirect = 1'b1; redirect_pc = 32'h0000_0103; mem_ready = 1'b0;
        @(negedge clk);
        redirect = 1'b0; redirect_pc = '0; mem_ready = 1'b1;
        check("c_target_addr", imem_addr, 32'h100);
        check("c_target_req_valid", 32'(imem_req_valid), 32'd1);
        found = 1'b0;
        for (int k = 4; k < 24; k++) begin
            if (!found && instr_valid) begin
                found = 1'b1;
                check("c_first_pc", instr_pc, 32'h100);
                check("c_first_instr", instr, 32'h100 ^ MAGIC);
                check("c_first_latency", 32'(k), 32'(REDIR_K));
            end
            @(negedge clk);
        end
        check("c_response_seen", 32'(found), 32'd1);

        // Reset pulse mid-stream with three queued entries.
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("d_queued_valid", 32'(instr_valid), 32'd1);
        check("d_credit_full", 32'(imem_req_valid), 32'd0);
        check("d_addr_before", imem_addr, 32'h10);
        #2 rst = 1'b0;
        #1;
        check("d_instr_valid_cleared", 32'(instr_valid), 32'd0);
        check("d_req_valid_cleared", 32'(imem_req_valid), 32'd0);
        check("d_addr_cleared", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("d_first_req_valid", 32'(imem_req_valid), 32'd1);
        check("d_first_req_addr", imem_addr, 32'h0);

        // Address wrap from 0xFFFF_FFFC.
        do_reset();
        instr_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect = 1'b0; redirect_pc = '0;
        check("e_target_addr", imem_addr, 32'hFFFF_FFFC);
        check("e_target_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        check("e_wrap_addr", imem_addr, 32'h0);
        exp_pc = 32'hFFFF_FFFC;
        for (int k = 2; k < 12; k++) stream_step(1'b1);
        check("e_wrapped_stream", 32'((exp_pc >= 32'd8) && (exp_pc < 32'h100)), 32'd1);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue and ready decode: the response appears on instr in the cycle it arrives.
        do_reset();
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("byp_valid", 32'(instr_valid), 32'd1);
        check("byp_instr", instr, 32'h0 ^ MAGIC);
        check("byp_pc", instr_pc, 32'h0);
        @(negedge clk);
        check("byp_next_pc", instr_pc, 32'h4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting directly upstream of decode (CU, SignExtend, DataPath) in the RV32 core. It owns the program counter and issues word-aligned requests to a variable-latency instruction memory. Returned instructions are buffered, together with their PCs, in a small in-order queue that decode drains through a valid/ready handshake. A redirect from the branch logic flushes the queue, discards in-flight responses and restarts fetch at the target address.

## Interface
- DEPTH, 4: queue entries and the maximum number of outstanding memory requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  request pending.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  request address; always word-aligned.
- imem_rsp_valid  in  1  response beat; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode consumes the head.
- instr  out  32  head instruction.
- instr_pc  out  32  head PC.

## Operation
- State:
  - fetch_pc.
  - queue of DEPTH {instr, pc} entries, with rd_ptr, wr_ptr and count.
  - outstanding counter, 0..DEPTH.
  - discard counter, 0..DEPTH, a subset of outstanding.
  - pc FIFO of issued addresses; alternatively, issued addresses may be reconstructed from fetch_pc and outstanding.
- Request issue:
  - imem_req_valid = (count + outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0x0) and outstanding increments.
- Response handling:
  - Every rsp_valid decrements outstanding.
  - If discard > 0, the response is dropped and discard decrements.
  - Otherwise the response is pushed with its issue PC.
  - The credit rule guarantees a push never finds the queue full. No overflow check is required; an assertion is required.
- Pop: on instr_valid && instr_ready, rd_ptr advances.
  - Popping from empty is a no-op.
  - Push and pop in the same cycle leave count unchanged.
- Redirect, in the cycle it is asserted:
  - The pop in that cycle completes normally, since the consumed instruction is the redirecting one.
  - All queue entries are then cleared (count = 0).
  - A response arriving that cycle is dropped.
  - A request accepted that cycle is stale.
  - Next-cycle discard = all requests still in flight after this cycle's accept and response.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Requests to the new target may issue from the next cycle, still subject to the credit rule; discard does not block issue.
- Back-to-back redirects: the later one wins, and discard accumulates correctly.

## Timing
- Reset values: imem_req_valid 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, all counters 0. Async assertion clears state immediately.
- Reset mid-operation: all in-flight responses are forgotten. The memory is reset by the same rst, so no stale beats follow.
- imem_req_valid rises in the first clock edge after rst deasserts.
- Latency without bypass: a response accepted at edge N is visible on instr/instr_valid after edge N, i.e. one register stage.
- Steady state with single-cycle memory and instr_ready held 1: one instruction per cycle.
- Outputs instr_valid, instr, instr_pc, imem_req_valid and imem_addr are registered or derived from registers only. The exception is bypass mode (see Configuration).
- Redirect to first new request: one cycle. Redirect to first valid instruction: memory latency + 1.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When the queue is empty, discard == 0 and imem_rsp_valid is high, instr_valid/instr/instr_pc are driven combinationally from the response.
  - If instr_ready is also high, the word is consumed without being written.
  - A redirect in the same cycle suppresses bypass.
- Undefined: no combinational path from imem_rsp_* to instr_*; minimum queue latency is one cycle.

## Test plan
- Reset release, memory always ready with 1-cycle latency, instr_ready=1:
  - instr_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - imem_addr leads instr_pc by the memory latency.
- instr_ready=0 for 10 cycles:
  - count + outstanding saturates at 4 and imem_req_valid drops.
  - After release, 4 instructions drain in order with no loss or duplication.
- 3-cycle memory with 2 requests in flight, then redirect to 0x0000_0103:
  - Both responses are dropped.
  - The next imem_addr is 0x100 and the next instr_pc is 0x100.
- Redirect in the same cycle as a pop, a response and a request accept:
  - The popped entry counts as consumed.
  - The response and the accepted request are both discarded.
  - The next delivered PC is the target.
- rst pulsed low mid-stream with 3 queued entries:
  - instr_valid = 0 immediately.
  - The first request after release is at RESET_PC.
- fetch_pc at 0xFFFF_FFFC: the next address wraps to 0x0000_0000.
- With FETCH_QUEUE_BYPASS_EN, empty queue and instr_ready=1: response data appears on instr in the same cycle.
